arm_ctrl_datamem: RTL and testbench

- Control-and-memory slice of the single-cycle LEGv8 datapath.
- Decodes the 11-bit instruction opcode (instruction[31:21]) into main control signals, derives the 6-bit ALU operation code, and holds the 64-bit data memory.
- The data memory is driven by the internally decoded mem_read and mem_write.
- Sits between the instruction memory/register bank and the ALU/writeback mux.

---
 rtl/arm_ctrl_pkg.sv | 48 ++++
 rtl/arm_data_mem.sv | 37 +++
 rtl/arm_ctrl_datamem.sv | 93 +++++++++
 tb/tb_arm_ctrl_datamem.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared opcode, ALU-operation and control-bundle definitions for the LEGv8 control/data-memory slice.
// The optional EOR opcode constant is always present; its decode is enabled by ARM_CTRL_EOR_EN.
package arm_ctrl_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;

  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD   = 2'b11;

  localparam logic [5:0] ALU_CTL_AND   = 6'b000000;
  localparam logic [5:0] ALU_CTL_ORR   = 6'b000001;
  localparam logic [5:0] ALU_CTL_ADD   = 6'b000010;
  localparam logic [5:0] ALU_CTL_EOR   = 6'b000011;
  localparam logic [5:0] ALU_CTL_SUB   = 6'b000110;
  localparam logic [5:0] ALU_CTL_PASSB = 6'b000111;

  typedef struct packed {
    logic       regToLoc;
    logic       aluSrc;
    logic       memToReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic [1:0] aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE  = '{regToLoc: 1'b0, aluSrc: 1'b0, memToReg: 1'b0, regWrite: 1'b0,
                                   memRead: 1'b0, memWrite: 1'b0, branch: 1'b0, aluOp: ALU_OP_MEM};
  localparam ctrl_t CTRL_RTYPE = '{regToLoc: 1'b0, aluSrc: 1'b0, memToReg: 1'b0, regWrite: 1'b1,
                                   memRead: 1'b0, memWrite: 1'b0, branch: 1'b0, aluOp: ALU_OP_RTYPE};
  localparam ctrl_t CTRL_LDUR  = '{regToLoc: 1'b0, aluSrc: 1'b1, memToReg: 1'b1, regWrite: 1'b1,
                                   memRead: 1'b1, memWrite: 1'b0, branch: 1'b0, aluOp: ALU_OP_MEM};
  localparam ctrl_t CTRL_STUR  = '{regToLoc: 1'b1, aluSrc: 1'b1, memToReg: 1'b0, regWrite: 1'b0,
                                   memRead: 1'b0, memWrite: 1'b1, branch: 1'b0, aluOp: ALU_OP_MEM};
  localparam ctrl_t CTRL_CBZ   = '{regToLoc: 1'b1, aluSrc: 1'b0, memToReg: 1'b0, regWrite: 1'b0,
                                   memRead: 1'b0, memWrite: 1'b0, branch: 1'b1, aluOp: ALU_OP_BRANCH};

endpackage

// File: rtl/arm_data_mem.sv
// Word-indexed 64-bit data memory with combinational read and an asynchronous clear of every word.
module arm_data_mem #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_LSB  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [63:0] rdata_o
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [63:0]      mem_q [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             unusedAddr;

  // Only the index field selects a word: higher bits wrap, lower bits pick the containing word.
  assign idx        = addr_i[ADDR_LSB +: IDX_W];
  assign unusedAddr = ^addr_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx] <= wdata_i;
    end
  end

  assign rdata_o = (re_i && !reset) ? mem_q[idx] : 64'h0;

endmodule

// File: rtl/arm_ctrl_datamem.sv
// LEGv8 main control decode, ALU control and data memory for the single-cycle datapath.
// Define ARM_CTRL_EOR_EN to accept EOR as an R-type instruction.
module arm_ctrl_datamem
  import arm_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_LSB  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        reg_to_loc,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [5:0]  alu_ctl,
  output logic [63:0] mem_rdata,
  output logic        illegal_op
);

  ctrl_t      ctrl;
  logic       illegal;
  logic [5:0] aluCtl;

  // CBZ ignores its low three opcode bits, so it is matched on the prefix before the exact opcodes.
  always_comb begin
    ctrl    = CTRL_NONE;
    illegal = 1'b0;
    if (opcode[10:3] == OP_CBZ_PFX) begin
      ctrl = CTRL_CBZ;
    end else begin
      case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_ORR: ctrl = CTRL_RTYPE;
`ifdef ARM_CTRL_EOR_EN
        OP_EOR:  ctrl = CTRL_RTYPE;
`endif
        OP_LDUR: ctrl = CTRL_LDUR;
        OP_STUR: ctrl = CTRL_STUR;
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    aluCtl = ALU_CTL_ADD;
    case (ctrl.aluOp)
      ALU_OP_BRANCH: aluCtl = ALU_CTL_PASSB;
      ALU_OP_RTYPE: begin
        case (opcode)
          OP_SUB:  aluCtl = ALU_CTL_SUB;
          OP_AND:  aluCtl = ALU_CTL_AND;
          OP_ORR:  aluCtl = ALU_CTL_ORR;
`ifdef ARM_CTRL_EOR_EN
          OP_EOR:  aluCtl = ALU_CTL_EOR;
`endif
          default: aluCtl = ALU_CTL_ADD;
        endcase
      end
      default: aluCtl = ALU_CTL_ADD;
    endcase
  end

  assign reg_to_loc = ctrl.regToLoc;
  assign alu_src    = ctrl.aluSrc;
  assign mem_to_reg = ctrl.memToReg;
  assign reg_write  = ctrl.regWrite;
  assign mem_read   = ctrl.memRead;
  assign mem_write  = ctrl.memWrite;
  assign branch     = ctrl.branch;
  assign alu_op     = ctrl.aluOp;
  assign alu_ctl    = aluCtl;
  assign illegal_op = illegal;

  arm_data_mem #(
    .MEM_WORDS(MEM_WORDS),
    .ADDR_LSB (ADDR_LSB)
  ) uDataMem (
    .clk    (clk),
    .reset  (reset),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .we_i   (ctrl.memWrite),
    .re_i   (ctrl.memRead),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_arm_ctrl_datamem.sv
// Directed scoreboard bench for arm_ctrl_datamem: decode, ALU control, memory store/load, wrap and reset.
// Expectations for opcode 11001010000 follow ARM_CTRL_EOR_EN.
module tb_arm_ctrl_datamem;

  localparam int MEM_WORDS = 32;

  localparam logic [8:0] C_NONE  = 9'b0_0_0_0_0_0_0_00;
  localparam logic [8:0] C_RTYPE = 9'b0_0_0_1_0_0_0_10;
  localparam logic [8:0] C_LDUR  = 9'b0_1_1_1_1_0_0_00;
  localparam logic [8:0] C_STUR  = 9'b1_1_0_0_0_1_0_00;
  localparam logic [8:0] C_CBZ   = 9'b1_0_0_0_0_0_1_01;

  typedef struct {
    string       tag;
    logic [8:0]  ctrl;
    logic [5:0]  aluCtl;
    logic        illegal;
    logic [63:0] rdata;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [10:0] opcode;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        reg_to_loc, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal_op;
  logic [1:0]  alu_op;
  logic [5:0]  alu_ctl;
  logic [63:0] mem_rdata;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  arm_ctrl_datamem #(.MEM_WORDS(MEM_WORDS), .ADDR_LSB(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .reg_to_loc(reg_to_loc),
    .branch    (branch),
    .mem_read  (mem_read),
    .mem_to_reg(mem_to_reg),
    .alu_op    (alu_op),
    .mem_write (mem_write),
    .alu_src   (alu_src),
    .reg_write (reg_write),
    .alu_ctl   (alu_ctl),
    .mem_rdata (mem_rdata),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one instruction's inputs and records what the slice must produce for it.
  task automatic applyStimulus(input logic [10:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                               input string tag, input logic [8:0] expCtrl, input logic [5:0] expAlu,
                               input logic expIllegal, input logic [63:0] expRdata);
    exp_t e;
    opcode    = op;
    mem_addr  = addr;
    mem_wdata = wdata;
    e.tag     = tag;
    e.ctrl    = expCtrl;
    e.aluCtl  = expAlu;
    e.illegal = expIllegal;
    e.rdata   = expRdata;
    sbQ.push_back(e);
  endtask

  // Lets the combinational outputs settle, then retires every pending scoreboard entry.
  task automatic checkOutput();
    exp_t       e;
    logic [8:0] obsCtrl;
    #2;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      obsCtrl = {reg_to_loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
      checks++;
      assert (obsCtrl === e.ctrl) else begin
        errors++;
        $error("[TB] FAIL %s ctrl: observed %b expected %b", e.tag, obsCtrl, e.ctrl);
      end
      checks++;
      assert (alu_ctl === e.aluCtl) else begin
        errors++;
        $error("[TB] FAIL %s alu_ctl: observed %b expected %b", e.tag, alu_ctl, e.aluCtl);
      end
      checks++;
      assert (illegal_op === e.illegal) else begin
        errors++;
        $error("[TB] FAIL %s illegal_op: observed %b expected %b", e.tag, illegal_op, e.illegal);
      end
      checks++;
      assert (mem_rdata === e.rdata) else begin
        errors++;
        $error("[TB] FAIL %s mem_rdata: observed %h expected %h", e.tag, mem_rdata, e.rdata);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    @(negedge clk);
    applyStimulus(11'b11111000010, 64'h10, 64'h0, "ldur_in_reset", C_LDUR, 6'b000010, 1'b0, 64'h0);
    checkOutput();
    reset = 1'b0;

    @(negedge clk);
    applyStimulus(11'b10001011000, 64'h0, 64'h0, "add", C_RTYPE, 6'b000010, 1'b0, 64'h0);
    checkOutput();
    applyStimulus(11'b11001011000, 64'h0, 64'h0, "sub", C_RTYPE, 6'b000110, 1'b0, 64'h0);
    checkOutput();
    applyStimulus(11'b10001010000, 64'h0, 64'h0, "and", C_RTYPE, 6'b000000, 1'b0, 64'h0);
    checkOutput();
    applyStimulus(11'b10101010000, 64'h0, 64'h0, "orr", C_RTYPE, 6'b000001, 1'b0, 64'h0);
    checkOutput();

    // Store then load the same word, including wrapped and misaligned aliases.
    @(negedge clk);
    applyStimulus(11'b11111000000, 64'h10, 64'hDEADBEEF_CAFEF00D, "stur", C_STUR, 6'b000010, 1'b0, 64'h0);
    checkOutput();
    @(negedge clk);
    applyStimulus(11'b11111000010, 64'h10, 64'h0, "ldur", C_LDUR, 6'b000010, 1'b0, 64'hDEADBEEF_CAFEF00D);
    checkOutput();
    applyStimulus(11'b11111000010, 64'h10 + MEM_WORDS * 8, 64'h0, "ldur_wrap", C_LDUR, 6'b000010, 1'b0,
                  64'hDEADBEEF_CAFEF00D);
    checkOutput();
    applyStimulus(11'b11111000010, 64'h15, 64'h0, "ldur_misalign", C_LDUR, 6'b000010, 1'b0,
                  64'hDEADBEEF_CAFEF00D);
    checkOutput();
    applyStimulus(11'b11111000010, 64'h18, 64'h0, "ldur_other", C_LDUR, 6'b000010, 1'b0, 64'h0);
    checkOutput();

    applyStimulus(11'b10110100000, 64'h0, 64'h0, "cbz0", C_CBZ, 6'b000111, 1'b0, 64'h0);
    checkOutput();
    applyStimulus(11'b10110100111, 64'h0, 64'h0, "cbz7", C_CBZ, 6'b000111, 1'b0, 64'h0);
    checkOutput();

    // An illegal opcode across an edge must not touch memory.
    @(negedge clk);
    applyStimulus(11'b00000000000, 64'h10, 64'h1111_2222_3333_4444, "illegal", C_NONE, 6'b000010, 1'b1, 64'h0);
    checkOutput();
    @(negedge clk);
    applyStimulus(11'b11111000010, 64'h10, 64'h0, "ldur_after_illegal", C_LDUR, 6'b000010, 1'b0,
                  64'hDEADBEEF_CAFEF00D);
    checkOutput();

`ifdef ARM_CTRL_EOR_EN
    applyStimulus(11'b11001010000, 64'h0, 64'h0, "eor", C_RTYPE, 6'b000011, 1'b0, 64'h0);
`else
    applyStimulus(11'b11001010000, 64'h0, 64'h0, "eor", C_NONE, 6'b000010, 1'b1, 64'h0);
`endif
    checkOutput();

    // Asynchronous reset pulse between edges wipes stored data.
    @(negedge clk);
    applyStimulus(11'b11111000000, 64'h8, 64'h1234, "stur_8", C_STUR, 6'b000010, 1'b0, 64'h0);
    checkOutput();
    @(negedge clk);
    applyStimulus(11'b11111000010, 64'h8, 64'h0, "ldur_8", C_LDUR, 6'b000010, 1'b0, 64'h1234);
    checkOutput();
    reset = 1'b1;
    applyStimulus(11'b11111000010, 64'h8, 64'h0, "ldur_8_in_reset", C_LDUR, 6'b000010, 1'b0, 64'h0);
    checkOutput();
    reset = 1'b0;
    applyStimulus(11'b11111000010, 64'h8, 64'h0, "ldur_8_after_reset", C_LDUR, 6'b000010, 1'b0, 64'h0);
    checkOutput();
    applyStimulus(11'b11111000010, 64'h10, 64'h0, "ldur_10_after_reset", C_LDUR, 6'b000010, 1'b0, 64'h0);
    checkOutput();

    // A store on an edge while reset is held is dropped.
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(11'b11111000000, 64'h8, 64'h5555, "stur_in_reset", C_STUR, 6'b000010, 1'b0, 64'h0);
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(11'b11111000010, 64'h8, 64'h0, "ldur_after_dropped", C_LDUR, 6'b000010, 1'b0, 64'h0);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
